// File: rtl/serial_char_rx_pkg.sv
// Shared types and constants for the serial character receiver.
// SERIAL_CHAR_RX_PARITY_EN adds an even-parity bit after the data bits.
package serial_char_rx_pkg;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic [7:0] ASCII_B     = 8'h62;
  localparam logic [7:0] ASCII_E     = 8'h65;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
`ifdef SERIAL_CHAR_RX_PARITY_EN
    ST_PARITY    = 3'd5,
`endif
    ST_WAIT_IDLE = 3'd4
  } state_e;

  function automatic logic even_par(
    input logic [FRAME_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/serial_char_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages reset to RST_VAL so an idle line reads idle from reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;
  logic s1_d;
  logic s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/serial_char_rx.sv
// 8N1 serial character receiver with mid-bit sampling.
// Define SERIAL_CHAR_RX_PARITY_EN for an 8E1 frame with parity check.
module serial_char_rx
  import serial_char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

  logic rx_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;

  logic shift_en;
  logic load_en;
  logic ferr_set;

  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                 data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rx_s)
  );

`ifdef SERIAL_CHAR_RX_PARITY_EN
  logic perr_set;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    ferr_set  = 1'b0;
`ifdef SERIAL_CHAR_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_CHAR_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_CHAR_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s != even_par(shift_q)) begin
            perr_set = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end else begin
            state_d  = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            load_en = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Pulses are registered so they line up with the updated data word.
  always_comb begin
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = load_en;
    ferr_d  = ferr_set;
`ifdef SERIAL_CHAR_RX_PARITY_EN
    perr_d  = perr_set;
`endif
    if (shift_en) shift_d = {rx_s, shift_q[FRAME_DATA_BITS-1:1]};
    if (load_en)  data_d  = shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_CHAR_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_CHAR_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef SERIAL_CHAR_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_char_rx.sv
// Directed bench for serial_char_rx at 16 clocks per bit.
// Parity steps run only when SERIAL_CHAR_RX_PARITY_EN is defined.
module tb_serial_char_rx;
  import serial_char_rx_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int ntests = 0;
  int nfail  = 0;

  int nvalid = 0;
  int nferr  = 0;
  int nperr  = 0;
  int nmulti = 0;
  int nbusy_bad = 0;
  logic prev_busy = 1'b0;
  logic [7:0] dq[$];

  serial_char_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_busy <= busy;
    if (valid === 1'b1) begin
      nvalid <= nvalid + 1;
      dq.push_back(data);
      if (busy !== 1'b0 || prev_busy !== 1'b1) nbusy_bad <= nbusy_bad + 1;
    end
    if (frame_err === 1'b1) nferr <= nferr + 1;
    if (parity_err === 1'b1) nperr <= nperr + 1;
    if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1)
      nmulti <= nmulti + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef SERIAL_CHAR_RX_PARITY_EN
    bit_time((^b) ^ par_flip);
`endif
    bit_time(stop_v);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, f0, p0, base;
    logic [7:0] begin_str [5];
    begin_str[0] = 8'h42;
    begin_str[1] = 8'h45;
    begin_str[2] = 8'h47;
    begin_str[3] = 8'h49;
    begin_str[4] = 8'h4E;

    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(10);

    v0 = nvalid; f0 = nferr; base = dq.size();
    send_frame(ASCII_B, 1'b1, 1'b0);
    idle(20);
    check("b_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("b_dq", 32'(dq[base]), 32'h62);
    check("b_data", 32'(data), 32'h62);
    check("b_ferr_cnt", 32'(nferr - f0), 32'd0);
    check("b_busy_fall", 32'(nbusy_bad), 32'd0);

    v0 = nvalid; base = dq.size();
    for (int i = 0; i < 5; i++) send_frame(begin_str[i], 1'b1, 1'b0);
    idle(20);
    check("begin_cnt", 32'(nvalid - v0), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("begin_%0d", i), 32'(dq[base+i]), 32'(begin_str[i]));

    v0 = nvalid; f0 = nferr; p0 = nperr;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 32'h1);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 32'h0);
    check("glitch_pulses", 32'((nvalid - v0) + (nferr - f0) + (nperr - p0)), 32'd0);
    idle(10);

    v0 = nvalid; f0 = nferr;
    send_frame(ASCII_E, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check("ferr_cnt", 32'(nferr - f0), 32'd1);
    check("ferr_valid", 32'(nvalid - v0), 32'd0);
    check("ferr_data", 32'(data), 32'h4E);
    check("break_busy", 32'(busy), 32'h1);
    idle(20);
    check("break_end_busy", 32'(busy), 32'h0);
    check("break_end_valid", 32'(nvalid - v0), 32'd0);
    check("break_end_ferr", 32'(nferr - f0), 32'd1);

    v0 = nvalid; f0 = nferr; base = dq.size();
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'(8'h6E >> i));
    rxd = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data", 32'(data), 32'h00);
    reset = 1'b0;
    idle(20);
    check("midrst_busy", 32'(busy), 32'h0);
    send_frame(8'h64, 1'b1, 1'b0);
    idle(20);
    check("midrst_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("midrst_dq", 32'(dq[base]), 32'h64);
    check("midrst_ferr", 32'(nferr - f0), 32'd0);

    v0 = nvalid; base = dq.size();
    send_frame(ASCII_SPACE, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(20);
    check("edge_cnt", 32'(nvalid - v0), 32'd3);
    check("edge_space", 32'(dq[base]), 32'h20);
    check("edge_ff", 32'(dq[base+1]), 32'hFF);
    check("edge_00", 32'(dq[base+2]), 32'h00);

`ifdef SERIAL_CHAR_RX_PARITY_EN
    v0 = nvalid; p0 = nperr;
    send_frame(8'h6E, 1'b1, 1'b1);
    idle(20);
    check("par_bad_perr", 32'(nperr - p0), 32'd1);
    check("par_bad_valid", 32'(nvalid - v0), 32'd0);
    check("par_bad_data", 32'(data), 32'h00);
    v0 = nvalid; p0 = nperr;
    send_frame(8'h6E, 1'b1, 1'b0);
    idle(20);
    check("par_ok_valid", 32'(nvalid - v0), 32'd1);
    check("par_ok_data", 32'(data), 32'h6E);
    check("par_ok_perr", 32'(nperr - p0), 32'd0);
`else
    check("no_par_perr", 32'(nperr), 32'd0);
`endif

    check("mutex", 32'(nmulti), 32'd0);
    check("busy_fall_all", 32'(nbusy_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
